// File: rtl/game_pkg.sv
// Match-flow types and constants shared by the scoring logic and the score digit renderer.
package game_pkg;

   typedef enum logic [1:0] {PLAY, GOAL_HOLD, RESPAWN, OVER} match_state_t;

   localparam int SCORE_W = 4;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   function automatic logic [1:0] winner_code(input logic [SCORE_W-1:0] p1,
                                              input logic [SCORE_W-1:0] p2);
      if (p1 > p2)      return WIN_P1;
      else if (p2 > p1) return WIN_P2;
      else              return WIN_DRAW;
   endfunction

endpackage

// File: rtl/match_timer.sv
// Frame-tick divider feeding a match countdown in seconds that stops at zero.
module match_timer #(
   parameter int MATCH_SECONDS  = 90,
   parameter int FRAMES_PER_SEC = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       run,
   input  logic       frame_tick,
   output logic [7:0] time_left,
   output logic       expired
);

   localparam int              FC_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [7:0]      START   = 8'(MATCH_SECONDS);

   logic [FC_W-1:0] frame_cnt;
   logic            wrap;

   assign wrap = run && frame_tick && (frame_cnt == FC_LAST);

   // Pulses on the tick that takes the countdown from 1 to 0 so the FSM can leave PLAY on that edge.
   assign expired = wrap && (time_left == 8'd1);

   always_ff @(posedge clk) begin
      if (!reset_n || load) begin
         frame_cnt <= '0;
         time_left <= START;
      end else if (run && frame_tick) begin
         if (wrap) begin
            frame_cnt <= '0;
            if (time_left != 8'd0) time_left <= time_left - 8'd1;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Match scoring and flow control: goal edge detection, celebration hold, respawn and game-over.
module score_keeper
   import game_pkg::*;
#(
   parameter int WIN_SCORE        = 5,
   parameter int MATCH_SECONDS    = 90,
   parameter int FRAMES_PER_SEC   = 60,
   parameter int CELEBRATE_FRAMES = 120
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_tick,
   input  logic               goal_left,
   input  logic               goal_right,
   input  logic               new_match,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [7:0]         time_left,
   output logic               freeze,
   output logic               round_reset,
   output logic               game_over,
   output logic [1:0]         winner
);

   localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
   localparam int                 HC_W      = (CELEBRATE_FRAMES > 1) ? $clog2(CELEBRATE_FRAMES) : 1;
   localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(CELEBRATE_FRAMES - 1);

   match_state_t    state;
   logic [HC_W-1:0] hold_cnt;
   logic            goal_left_q;
   logic            goal_right_q;
   logic            edge_left;
   logic            edge_right;
   logic            expired;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN_S) ? WIN_S : s + SCORE_W'(1);
   endfunction

   assign edge_left  = goal_left  && !goal_left_q;
   assign edge_right = goal_right && !goal_right_q;

   match_timer #(
      .MATCH_SECONDS (MATCH_SECONDS),
      .FRAMES_PER_SEC(FRAMES_PER_SEC)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (new_match),
      .run       (state == PLAY),
      .frame_tick(frame_tick),
      .time_left (time_left),
      .expired   (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= PLAY;
         score_p1     <= '0;
         score_p2     <= '0;
         hold_cnt     <= '0;
         freeze       <= 1'b0;
         round_reset  <= 1'b0;
         game_over    <= 1'b0;
         winner       <= WIN_NONE;
         goal_left_q  <= 1'b0;
         goal_right_q <= 1'b0;
      end else begin
         goal_left_q  <= goal_left;
         goal_right_q <= goal_right;
         round_reset  <= 1'b0;
         if (new_match) begin
            state       <= RESPAWN;
            score_p1    <= '0;
            score_p2    <= '0;
            hold_cnt    <= '0;
            freeze      <= 1'b1;
            round_reset <= 1'b1;
            game_over   <= 1'b0;
            winner      <= WIN_NONE;
         end else begin
            unique case (state)
               PLAY: begin
                  // Simultaneous edges are ambiguous contact and fall through to the timeout check.
                  if (edge_left ^ edge_right) begin
                     if (edge_right) score_p1 <= sat_inc(score_p1);
                     else            score_p2 <= sat_inc(score_p2);
                     hold_cnt <= '0;
                     freeze   <= 1'b1;
                     state    <= GOAL_HOLD;
                  end else if (expired || time_left == 8'd0) begin
                     state     <= OVER;
                     freeze    <= 1'b1;
                     game_over <= 1'b1;
                     winner    <= winner_code(score_p1, score_p2);
                  end
               end
               GOAL_HOLD: begin
                  if (frame_tick) begin
                     if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (score_p1 == WIN_S || score_p2 == WIN_S || time_left == 8'd0) begin
                           state     <= OVER;
                           game_over <= 1'b1;
                           winner    <= winner_code(score_p1, score_p2);
                        end else begin
                           state       <= RESPAWN;
                           round_reset <= 1'b1;
                        end
                     end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                     end
                  end
               end
               RESPAWN: begin
                  state  <= PLAY;
                  freeze <= 1'b0;
               end
               OVER: begin
               end
               default: state <= PLAY;
            endcase
         end
      end
   end

   // The win check fires before any score can pass WIN_SCORE; sat_inc is only a safety net.
   assert property (@(posedge clk) disable iff (!reset_n) (score_p1 <= WIN_S) && (score_p2 <= WIN_S));

endmodule
